fir_ctrl: RTL
=============

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter NUM_PHASES, default 3, SHALL set the number of MAC phases per output sample (legal range 1..4).
REQ-002 Port Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port enable  input  1  SHALL request continuous filtering.
REQ-005 Port Empty  input  1  SHALL be the input-sample FIFO empty flag.
REQ-006 Port PullOut  output  1  SHALL be the FIFO pop strobe; FIFO data is valid the following cycle.
REQ-007 Port shift_en  output  1  SHALL shift the new sample into the datapath delay line.
REQ-008 Port count  output  2  SHALL be the datapath phase select.
REQ-009 Port valid  output  1  SHALL qualify count as an active MAC phase.
REQ-010 Port acc_clr  output  1  SHALL make the accumulator load, not add, the current sub-products.
REQ-011 Port acc_en  output  1  SHALL enable the accumulator.
REQ-012 Port out_valid  output  1  SHALL flag the filter result as valid.
REQ-013 Port out_ready  input  1  SHALL flag that the consumer accepts the result.
REQ-014 Port busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, POP, LOAD, MAC, DRAIN and HOLD; all outputs SHALL be registered (Moore).
REQ-016 IDLE: enable=1 and Empty=0 SHALL go to POP; otherwise the FSM SHALL stay in IDLE.
REQ-017 POP SHALL assert PullOut for exactly 1 cycle, then go to LOAD.
REQ-018 LOAD SHALL assert shift_en for exactly 1 cycle, then go to MAC with count=0.
REQ-019 MAC SHALL assert valid and acc_en, and step count 0,1,..,NUM_PHASES-1 with one value per cycle.
REQ-020 MAC SHALL assert acc_clr only when count=0.
REQ-021 After the last phase, MAC SHALL go to DRAIN for 1 cycle (accumulator register latency), then to HOLD.
REQ-022 HOLD SHALL hold out_valid=1 until out_ready=1, and SHALL NOT drop out_valid before acceptance.
REQ-023 On acceptance in HOLD with enable=1 and Empty=0, the FSM SHALL go directly to POP; otherwise it SHALL go to IDLE.
REQ-024 Latency SHALL be: POP at cycle t gives out_valid at t+3+NUM_PHASES; the sustained period with out_ready=1 SHALL be 4+NUM_PHASES cycles.
REQ-025 If enable deasserts mid-sequence, the current sample SHALL complete through HOLD, then the FSM SHALL go to IDLE.
REQ-026 A change on Empty after POP SHALL NOT affect the sequence in progress.
REQ-027 count SHALL be 0 and valid, acc_clr and acc_en SHALL be 0 outside MAC.
REQ-028 PullOut SHALL never assert while Empty=1, as sampled in the decision cycle.
REQ-029 out_ready outside HOLD SHALL be ignored.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, with every output 0, independent of Clk.
REQ-031 Reset asserted mid-operation SHALL abandon the sample; no out_valid SHALL follow for it.
REQ-032 The first transition SHALL occur on the first Clk edge after Reset deasserts.

Configuration
REQ-033 With FIR_CTRL_STALL_CNT_EN defined, port stall_cnt (output, 16 bits) SHALL count cycles in HOLD with out_ready=0, saturate at 0xFFFF, and clear only on reset.
REQ-034 Without FIR_CTRL_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset low, then high, with Empty=1, enable=1 -> stays IDLE, PullOut never 1, busy=0, all outputs 0.
REQ-036 Empty=0, enable=1, out_ready=1, NUM_PHASES=3 -> PullOut at t, shift_en at t+1, count 0,1,2 at t+2..t+4 with acc_clr only at t+2, out_valid at t+6, next PullOut at t+7.
REQ-037 out_ready=0 for 5 cycles in HOLD -> out_valid stays 1 all 5 cycles, then is accepted; stall_cnt=5 with the macro defined.
REQ-038 enable dropped during MAC count=1 -> sample completes, out_valid once, then IDLE with no further PullOut.
REQ-039 Reset pulsed low during MAC count=2 -> all outputs 0 asynchronously, IDLE, no out_valid for that sample.
REQ-040 Empty rises in the same cycle as acceptance in HOLD -> transition to IDLE, no PullOut.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer for a multi-phase FIR datapath.
// Pops one sample from the input FIFO, shifts it into the delay line,
// runs NUM_PHASES accumulate phases, waits one cycle for the accumulator
// register, then holds out_valid until the consumer takes the result.
// All outputs are registered (Moore): each is decoded from the next state
// and stored alongside it, so they change only on Clk or on Reset.
// Optional feature: define FIR_CTRL_STALL_CNT_EN to add the 16-bit
// stall_cnt output counting HOLD cycles with out_ready low.

module fir_ctrl #(
    parameter int unsigned NUM_PHASES = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        enable,
    input  logic        Empty,
    output logic        PullOut,
    output logic        shift_en,
    output logic [1:0]  count,
    output logic        valid,
    output logic        acc_clr,
    output logic        acc_en,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FIR_CTRL_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        busy
);

    // Index of the final MAC phase; legal NUM_PHASES is 1..4.
    localparam logic [1:0] LastPhase = 2'(NUM_PHASES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StMac,
        StDrain,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] count_d;
    logic       pullout_d;
    logic       shift_en_d;
    logic       mac_d;
    logic       acc_clr_d;
    logic       out_valid_d;
    logic       busy_d;
    logic       start_ok;

    // A new sample may start only when requested and the FIFO has data now.
    assign start_ok = enable && !Empty;

    // Next-state and next phase-count selection.
    always_comb begin
        state_d = state_q;
        count_d = 2'd0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StLoad;
            end
            StLoad: begin
                // Enter MAC with phase 0.
                state_d = StMac;
            end
            StMac: begin
                if (count == LastPhase) begin
                    state_d = StDrain;
                end else begin
                    count_d = count + 2'd1;
                end
            end
            StDrain: begin
                // Accumulator output register needs one cycle to settle.
                state_d = StHold;
            end
            StHold: begin
                // enable/Empty are only consulted at acceptance, so a sample
                // in flight always completes.
                if (out_ready) begin
                    state_d = start_ok ? StPop : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        pullout_d   = 1'b0;
        shift_en_d  = 1'b0;
        mac_d       = 1'b0;
        acc_clr_d   = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            StIdle:  busy_d      = 1'b0;
            StPop:   pullout_d   = 1'b1;
            StLoad:  shift_en_d  = 1'b1;
            StMac: begin
                mac_d     = 1'b1;
                acc_clr_d = (count_d == 2'd0);
            end
            StDrain: busy_d      = 1'b1;
            StHold:  out_valid_d = 1'b1;
            default: busy_d      = 1'b0;
        endcase
    end

    // State and registered outputs; reset forces IDLE with all outputs low.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            PullOut   <= 1'b0;
            shift_en  <= 1'b0;
            count     <= 2'd0;
            valid     <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            PullOut   <= pullout_d;
            shift_en  <= shift_en_d;
            count     <= mac_d ? count_d : 2'd0;
            valid     <= mac_d;
            acc_clr   <= acc_clr_d;
            acc_en    <= mac_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

`ifdef FIR_CTRL_STALL_CNT_EN
    // Count consumer back-pressure cycles; saturates, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= 16'd0;
        end else if (state_q == StHold && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A pop strobe always belongs to an active sequence.
    a_pull_busy : assert property (@(posedge Clk) disable iff (!Reset) PullOut |-> busy);
    // Accumulator clear only on the first active phase.
    a_clr_phase0 : assert property (@(posedge Clk) disable iff (!Reset)
        acc_clr |-> (valid && count == 2'd0));
`endif

endmodule
